// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the 8-bit restoring divider.
package div_pkg;

  localparam int unsigned Width = 8;
  // One restoring step per quotient bit.
  localparam int unsigned Iters = Width;
  localparam int unsigned CntW  = $clog2(Iters);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// Trial subtraction a - b as a ripple of full adders (a + ~b + 1); borrow is the inverted carry.
module div_step
  import div_pkg::*;
(
  input  logic [Width:0] a_i,
  input  logic [Width:0] b_i,
  output logic [Width:0] diff_o,
  output logic           borrow_o
);

  logic [Width+1:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= Width; i++) begin : g_bit
    fa u_fa (
      .a_i  (a_i[i]),
      .b_i  (~b_i[i]),
      .ci_i (carry[i]),
      .s_o  (diff_o[i]),
      .co_o (carry[i+1])
    );
  end

  // No carry out of the top bit means a < b.
  assign borrow_o = ~carry[Width+1];

endmodule

// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  // Sum and carry of three input bits.
  always_comb begin
    s_o  = a_i ^ b_i ^ ci_i;
    co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
  end

endmodule

// File: rtl/restoring_div_8.sv
// 8-bit unsigned restoring divider: one quotient bit per cycle, divide-by-zero short cut.
module restoring_div_8
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  output logic [Width-1:0] Q,
  output logic [Width-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] rem_q, rem_d;
  // Dividend shifts out of the MSB while quotient bits shift in at the LSB.
  logic [Width-1:0] dvd_q, dvd_d;
  logic [Width-1:0] b_q, b_d;
  logic [Width-1:0] q_q, q_d;
  logic [Width-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  logic [Width:0]   rem_shift;
  logic [Width:0]   trial;
  logic             borrow;
  logic             unused_trial_msb;

  assign rem_shift = {rem_q, dvd_q[Width-1]};

  div_step u_step (
    .a_i      (rem_shift),
    .b_i      ({1'b0, b_q}),
    .diff_o   (trial),
    .borrow_o (borrow)
  );

  // A successful trial is always below the divisor, so its MSB is zero.
  assign unused_trial_msb = trial[Width];

  // Next-state: accept in idle/done, iterate in run, capture results on the last step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          if (B == '0) begin
            state_d = StDone;
            q_d     = '1;
            r_d     = A;
            dz_d    = 1'b1;
          end else begin
            state_d = StRun;
            rem_d   = '0;
            dvd_d   = A;
            b_d     = B;
            cnt_d   = '0;
            dz_d    = 1'b0;
          end
        end
      end
      StRun: begin
        rem_d = borrow ? rem_shift[Width-1:0] : trial[Width-1:0];
        dvd_d = {dvd_q[Width-2:0], ~borrow};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(Iters - 1)) begin
          state_d = StDone;
          q_d     = dvd_d;
          r_d     = rem_d;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign Q        = q_q;
  assign R        = r_q;
  assign div_zero = dz_q;
  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);

endmodule
